regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the 4x16 register file between NREQ write-back

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter_rr.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file geometry and the write-back payload type used by the
// arbiter, the register file and decode.
package regfile_wb_arbiter_pkg;

  localparam int unsigned NREG     = 4;
  localparam int unsigned AW       = 3;
  localparam int unsigned DW       = 16;
  localparam int unsigned NREQ_DEF = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between requesters and the register-file write port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ = regfile_wb_arbiter_pkg::NREQ_DEF
) ();

  logic [NREQ-1:0]                             req_valid;
  logic [NREQ-1:0]                             req_ready;
  logic [NREQ*regfile_wb_arbiter_pkg::AW-1:0]  req_addr;
  logic [NREQ*regfile_wb_arbiter_pkg::DW-1:0]  req_data;
  logic                                        wb_hold;
  logic                                        write;
  logic [regfile_wb_arbiter_pkg::AW-1:0]       wr_Addr;
  logic [regfile_wb_arbiter_pkg::DW-1:0]       wr_Data;
  logic [regfile_wb_arbiter_pkg::NREG-1:0]     pending;

  modport master (
    output req_valid, req_addr, req_data, wb_hold,
    input  req_ready, write, wr_Addr, wr_Data, pending
  );

  modport slave (
    input  req_valid, req_addr, req_data, wb_hold,
    output req_ready, write, wr_Addr, wr_Data, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant over i_req, search starts after the last
// granted index, which is remembered whenever a grant is issued.
module regfile_wb_arbiter_rr #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = regfile_wb_arbiter_pkg::idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant_c,
  output logic [IW-1:0]   o_gidx_c,
  output logic            o_any_c
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant_c = '0;
    o_gidx_c  = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_idx = IW'((int'(r_ptr) + k) % int'(NREQ));
      if (!w_found && i_en && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_grant_c[w_idx] = 1'b1;
        o_gidx_c         = w_idx;
      end
    end
    o_any_c = w_found;
  end

  // Reset points at the last index so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IW'(NREQ - 1);
    end else if (o_any_c) begin
      r_ptr <= o_gidx_c;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NREQ write-back sources through
// per-source one-entry buffers, round-robin grant and a registered write stage.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_w(NREQ);

  wb_req_t         r_buf [NREQ];
  logic [NREQ-1:0] r_full;
  logic            r_write;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;

  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_conflict;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_accept;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  logic [NREG-1:0] w_pending;

  regfile_wb_arbiter_rr #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (r_full),
    .i_en      (~bus.wb_hold),
    .o_grant_c (w_grant),
    .o_gidx_c  (w_gidx),
    .o_any_c   (w_any)
  );

  // A source may not queue a second write to a register that another buffer
  // still holds, which keeps per-register write order equal to accept order.
  always_comb begin
    w_conflict = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      for (int j = 0; j < int'(NREQ); j++) begin
        if (j != i && r_full[j] && !w_grant[j] &&
            r_buf[j].addr == bus.req_addr[i*AW +: AW]) begin
          w_conflict[i] = 1'b1;
        end
      end
    end
  end

  assign w_ready  = (~r_full | w_grant) & ~w_conflict & {NREQ{~rst}};
  assign w_accept = bus.req_valid & w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (w_accept[i]) begin
          r_full[i] <= 1'b1;
          r_buf[i]  <= wb_req_t'{addr: bus.req_addr[i*AW +: AW],
                                 data: bus.req_data[i*DW +: DW]};
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_any) begin
      r_write   <= 1'b1;
      r_wr_addr <= r_buf[w_gidx].addr;
      r_wr_data <= r_buf[w_gidx].data;
    end else begin
      r_write   <= 1'b0;
    end
  end

  // Addresses at or above NREG have no pending bit.
  always_comb begin
    w_pending = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      if (r_write && r_wr_addr == AW'(r)) begin
        w_pending[r] = 1'b1;
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (r_full[i] && r_buf[i].addr == AW'(r)) begin
          w_pending[r] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.write     = r_write;
  assign bus.wr_Addr   = r_wr_addr;
  assign bus.wr_Data   = r_wr_data;
  assign bus.pending   = w_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, checked
// against a cycle-level reference model with a write scoreboard.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned NREQ = 2;

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: buffered writes per source, last winner, and the write
  // visible on the register-file port in the current cycle.
  bit  m_full [NREQ];
  int  m_addr [NREQ];
  int  m_data [NREQ];
  int  m_ptr;
  bit  m_wr;
  int  m_wra;
  wr_t exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : model
    int              g;
    int              idx;
    int              a_i;
    bit              conf;
    logic [NREQ-1:0] rdy;
    logic [NREG-1:0] pend;

    chk("write_en", 32'(bus.write), 32'(m_wr));

    pend = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      if (m_wr && m_wra == r) pend[r] = 1'b1;
      for (int i = 0; i < int'(NREQ); i++)
        if (m_full[i] && m_addr[i] == r) pend[r] = 1'b1;
    end
    chk("pending", 32'(bus.pending), 32'(pend));

    g = -1;
    if (!bus.wb_hold) begin
      for (int k = 1; k <= int'(NREQ); k++) begin
        idx = (m_ptr + k) % int'(NREQ);
        if (g < 0 && m_full[idx]) g = idx;
      end
    end

    rdy = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      a_i  = int'(bus.req_addr[i*AW +: AW]);
      conf = 1'b0;
      for (int j = 0; j < int'(NREQ); j++)
        if (j != i && m_full[j] && j != g && m_addr[j] == a_i) conf = 1'b1;
      rdy[i] = (!m_full[i] || g == i) && !conf && !rst;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(rdy));

    if (rst) begin
      for (int i = 0; i < int'(NREQ); i++) m_full[i] = 1'b0;
      m_ptr = int'(NREQ) - 1;
      m_wr  = 1'b0;
      m_wra = 0;
    end else begin
      if (g >= 0) begin
        exp_q.push_back('{a: m_addr[g], d: m_data[g]});
        m_wr      = 1'b1;
        m_wra     = m_addr[g];
        m_full[g] = 1'b0;
        m_ptr     = g;
      end else begin
        m_wr = 1'b0;
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.req_valid[i] && rdy[i]) begin
          m_full[i] = 1'b1;
          m_addr[i] = int'(bus.req_addr[i*AW +: AW]);
          m_data[i] = int'(bus.req_data[i*DW +: DW]);
        end
      end
    end
  end

  // Scoreboard monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 bus.wr_Addr, bus.wr_Data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_Addr), 32'(e.a));
        chk("wr_data", 32'(bus.wr_Data), 32'(e.d));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input int v, input int a, input int d);
    bus.req_valid[i]          = (v != 0);
    bus.req_addr[i*AW +: AW]  = AW'(a);
    bus.req_data[i*DW +: DW]  = DW'(d);
  endtask

  task automatic idle_reqs();
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 0, 0, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      m_full[i] = 1'b0;
      m_addr[i] = 0;
      m_data[i] = 0;
    end
    m_ptr = int'(NREQ) - 1;
    m_wr  = 1'b0;
    m_wra = 0;

    rst         = 1'b1;
    bus.wb_hold = 1'b0;
    idle_reqs();
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_write",   32'(bus.write),     32'd0);
    chk("rst_wr_addr", 32'(bus.wr_Addr),   32'd0);
    chk("rst_wr_data", 32'(bus.wr_Data),   32'd0);
    chk("rst_pending", 32'(bus.pending),   32'd0);
    chk("rst_ready",   32'(bus.req_ready), 32'(2**NREQ - 1));
    cyc(2);

    // Single write with latency/pending timing
    set_req(0, 1, 2, 'hBEEF);
    cyc(1);
    idle_reqs();
    cyc(4);

    // Two sources streaming to distinct registers
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1, 0, int'($urandom_range(0, 65535)));
      set_req(1, 1, 1, int'($urandom_range(0, 65535)));
      cyc(1);
    end
    idle_reqs();
    cyc(4);

    // Same-register conflict held off until the older write is granted
    bus.wb_hold = 1'b1;
    set_req(0, 1, 3, 'h1111);
    cyc(1);
    set_req(0, 0, 0, 0);
    set_req(1, 1, 3, 'h2222);
    cyc(3);
    bus.wb_hold = 1'b0;
    cyc(1);
    idle_reqs();
    cyc(4);

    // Hold with both buffers full, then release
    bus.wb_hold = 1'b1;
    set_req(0, 1, 1, 'hA0A0);
    set_req(1, 1, 2, 'hB1B1);
    cyc(1);
    idle_reqs();
    cyc(5);
    bus.wb_hold = 1'b0;
    cyc(4);

    // Reset in the middle of streaming, then an out-of-range address
    for (int c = 0; c < 3; c++) begin
      set_req(0, 1, 0, 'h3000 + c);
      set_req(1, 1, 1, 'h4000 + c);
      cyc(1);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    idle_reqs();
    cyc(3);
    set_req(0, 1, 5, 'h5555);
    cyc(1);
    idle_reqs();
    cyc(4);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(NREQ); i++)
        set_req(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 65535)));
      bus.wb_hold = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      cyc(1);
    end
    rst         = 1'b0;
    bus.wb_hold = 1'b0;
    idle_reqs();
    cyc(10);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
